// File: rtl/casio_seg_driver_pkg.sv
// Shared definitions for the Casio-style 4-digit LED driver: glyphs,
// the dash/blank patterns and the digit scan order.
package casio_seg_driver_pkg;

  typedef enum logic [1:0] {
    DIG_HT = 2'd0,
    DIG_HO = 2'd1,
    DIG_MT = 2'd2,
    DIG_MO = 2'd3
  } digit_e;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] glyph;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/casio_seg_driver_bin2bcd.sv
// Combinational 0..63 binary to two-digit BCD split (tens, ones).
module casio_bin2bcd (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] base_s;

  // Compare chain selects the tens digit; the remainder below it is the ones digit.
  always_comb begin
    tens   = 4'd0;
    base_s = 6'd0;
    if (bin >= 6'd60) begin
      tens   = 4'd6;
      base_s = 6'd60;
    end else if (bin >= 6'd50) begin
      tens   = 4'd5;
      base_s = 6'd50;
    end else if (bin >= 6'd40) begin
      tens   = 4'd4;
      base_s = 6'd40;
    end else if (bin >= 6'd30) begin
      tens   = 4'd3;
      base_s = 6'd30;
    end else if (bin >= 6'd20) begin
      tens   = 4'd2;
      base_s = 6'd20;
    end else if (bin >= 6'd10) begin
      tens   = 4'd1;
      base_s = 6'd10;
    end else begin
      tens   = 4'd0;
      base_s = 6'd0;
    end
    ones = 4'(bin - base_s);
  end

endmodule

// File: rtl/casio_seg_driver.sv
// Multiplexed HH:MM 7-segment driver with per-digit blink and alarm colon flash.
// Inputs are shadowed once per frame so a frame never mixes old and new time.
module casio_seg_driver
  import casio_seg_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [3:0] blink_en,
  input  logic       ring,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_phase_r;
  digit_e             digit_r;
  digit_e             digit_nx_s;
  logic               scan_wrap_s;
  logic               frame_end_s;

  logic [4:0] hours_sh_r;
  logic [5:0] minutes_sh_r;
  logic [3:0] blink_sh_r;
  logic       ring_sh_r;

  logic [3:0] h_tens_s, h_ones_s, m_tens_s, m_ones_s;
  logic [3:0] bcd_s;
  logic       invalid_s;
  logic [6:0] seg_nx_s;
  logic       dp_nx_s;
  logic [3:0] an_nx_s;
  logic [6:0] seg_r;
  logic       dp_r;
  logic [3:0] an_r;

  assign scan_wrap_s = (scan_cnt_r == SCAN_LAST);
  assign frame_end_s = scan_wrap_s && (digit_r == DIG_MO);

  // Scan state register: dwell counter and current digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= '0;
      digit_r    <= DIG_HT;
    end else begin
      scan_cnt_r <= scan_wrap_s ? '0 : scan_cnt_r + SCAN_W'(1);
      digit_r    <= digit_nx_s;
    end
  end

  // Next digit: advance on dwell wrap in fixed HT->HO->MT->MO order.
  always_comb begin
    digit_nx_s = digit_r;
    if (scan_wrap_s) begin
      case (digit_r)
        DIG_HT:  digit_nx_s = DIG_HO;
        DIG_HO:  digit_nx_s = DIG_MT;
        DIG_MT:  digit_nx_s = DIG_MO;
        DIG_MO:  digit_nx_s = DIG_HT;
        default: digit_nx_s = DIG_HT;
      endcase
    end else begin
      digit_nx_s = digit_r;
    end
  end

  // Free-running blink timebase, unrelated to the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
    end
  end

  // Shadow registers: sample the live inputs on the last cycle of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hours_sh_r   <= 5'd0;
      minutes_sh_r <= 6'd0;
      blink_sh_r   <= 4'd0;
      ring_sh_r    <= 1'b0;
    end else if (frame_end_s) begin
      hours_sh_r   <= hours;
      minutes_sh_r <= minutes;
      blink_sh_r   <= blink_en;
      ring_sh_r    <= ring;
    end
  end

  casio_bin2bcd u_bcd_hours (
    .bin  ({1'b0, hours_sh_r}),
    .tens (h_tens_s),
    .ones (h_ones_s)
  );

  casio_bin2bcd u_bcd_minutes (
    .bin  (minutes_sh_r),
    .tens (m_tens_s),
    .ones (m_ones_s)
  );

  assign invalid_s = (hours_sh_r > 5'd23) || (minutes_sh_r > 6'd59);

  // Output decode for the digit currently being scanned.
  always_comb begin
    bcd_s    = 4'd0;
    seg_nx_s = SEG_BLANK;
    dp_nx_s  = 1'b0;
    an_nx_s  = 4'b1111;
    case (digit_r)
      DIG_HT:  begin bcd_s = h_tens_s; an_nx_s = 4'b1110; end
      DIG_HO:  begin bcd_s = h_ones_s; an_nx_s = 4'b1101; end
      DIG_MT:  begin bcd_s = m_tens_s; an_nx_s = 4'b1011; end
      DIG_MO:  begin bcd_s = m_ones_s; an_nx_s = 4'b0111; end
      default: begin bcd_s = 4'd0;     an_nx_s = 4'b1111; end
    endcase
    if (blink_phase_r && blink_sh_r[digit_r]) begin
      seg_nx_s = SEG_BLANK;
    end else if (invalid_s) begin
      seg_nx_s = SEG_DASH;
    end else begin
      seg_nx_s = bcd_to_seg(bcd_s);
    end
    if ((digit_r == DIG_HO) && !invalid_s) begin
      dp_nx_s = ring_sh_r ? ~blink_phase_r : 1'b1;
    end else begin
      dp_nx_s = 1'b0;
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= 7'h00;
      dp_r  <= 1'b0;
      an_r  <= 4'b1111;
    end else begin
      seg_r <= seg_nx_s;
      dp_r  <= dp_nx_s;
      an_r  <= an_nx_s;
    end
  end

  assign seg = seg_r;
  assign dp  = dp_r;
  assign an  = an_r;

endmodule
